// File: rtl/gpgpu_axil_csr_bank.sv
// rtl/gpgpu_axil_csr_bank.sv - AXI4-Lite CSR bank with RW/RO registers and write pulses; optional IRQ status register via GPGPU_CSR_IRQ_EN
module gpgpu_axil_csr_bank #(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_axilite_awvalid,
    output logic                           s_axilite_awready,
    input  logic [ADDR_WIDTH-1:0]          s_axilite_awaddr,
    input  logic [2:0]                     s_axilite_awprot,
    input  logic                           s_axilite_wvalid,
    output logic                           s_axilite_wready,
    input  logic [DATA_WIDTH-1:0]          s_axilite_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axilite_wstrb,
    output logic                           s_axilite_bvalid,
    input  logic                           s_axilite_bready,
    output logic [1:0]                     s_axilite_bresp,
    input  logic                           s_axilite_arvalid,
    output logic                           s_axilite_arready,
    input  logic [ADDR_WIDTH-1:0]          s_axilite_araddr,
    input  logic [2:0]                     s_axilite_arprot,
    output logic                           s_axilite_rvalid,
    input  logic                           s_axilite_rready,
    output logic [DATA_WIDTH-1:0]          s_axilite_rdata,
    output logic [1:0]                     s_axilite_rresp,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
    output logic [NUM_REGS-1:0]            reg_wr_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data_i,
    input  logic [DATA_WIDTH-1:0]          irq_set_i,
    output logic                           irq_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef GPGPU_CSR_IRQ_EN
    // The top register holds interrupt status and must stay host-accessible.
    localparam logic [NUM_REGS-1:0] IRQ_BIT = {1'b1, {(NUM_REGS-1){1'b0}}};
    localparam logic [NUM_REGS-1:0] RO_EFF  = RO_MASK & ~IRQ_BIT;
`else
    localparam logic [NUM_REGS-1:0] RO_EFF  = RO_MASK;
`endif

    logic                  aw_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_held;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_err;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] byte_mask;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_err;

    assign s_axilite_awready = !aw_held;
    assign s_axilite_wready  = !w_held;
    assign s_axilite_arready = !s_axilite_rvalid;

    assign aw_hs  = s_axilite_awvalid && !aw_held;
    assign w_hs   = s_axilite_wvalid && !w_held;
    assign ar_hs  = s_axilite_arvalid && !s_axilite_rvalid;
    // A commit retires both buffers and produces a B beat, so it waits for the B slot.
    assign commit = aw_held && w_held && (!s_axilite_bvalid || s_axilite_bready);

    assign wr_idx = aw_addr_q[OFF +: IDX_W];
    assign wr_err = (aw_addr_q >= SPAN);
    assign wr_ok  = commit && !wr_err && !RO_EFF[wr_idx];
    assign rd_idx = s_axilite_araddr[OFF +: IDX_W];
    assign rd_err = (s_axilite_araddr >= SPAN);

    // Expand the held byte strobes into a bit mask for merging.
    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            byte_mask[b*8 +: 8] = {8{w_strb_q[b]}};
        end
    end

    assign wr_merged = (regs[wr_idx] & ~byte_mask) | (w_data_q & byte_mask);

`ifdef GPGPU_CSR_IRQ_EN
    logic [DATA_WIDTH-1:0] irq_clr;
    logic [DATA_WIDTH-1:0] irq_next;
    logic                  unused_ok;

    // Write-one-to-clear on the status register; new set bits override a clear.
    always_comb begin
        irq_clr = '0;
        if (wr_ok && (wr_idx == IDX_W'(NUM_REGS-1))) begin
            irq_clr = w_data_q & byte_mask;
        end
        irq_next = (regs[NUM_REGS-1] & ~irq_clr) | irq_set_i;
    end

    assign irq_o     = |regs[NUM_REGS-1];
    assign unused_ok = &{1'b0, s_axilite_awprot, s_axilite_arprot};
`else
    logic unused_ok;

    assign irq_o     = 1'b0;
    assign unused_ok = &{1'b0, s_axilite_awprot, s_axilite_arprot, irq_set_i};
`endif

    // AW and W holding buffers fill independently and drain together on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
            end else if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axilite_awaddr;
            end
            if (commit) begin
                w_held <= 1'b0;
            end else if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axilite_wdata;
                w_strb_q <= s_axilite_wstrb;
            end
        end
    end

    // Write response: a commit reloads B even while the previous beat is being accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axilite_bvalid <= 1'b0;
            s_axilite_bresp  <= RESP_OKAY;
        end else if (commit) begin
            s_axilite_bvalid <= 1'b1;
            s_axilite_bresp  <= (wr_err || RO_EFF[wr_idx]) ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axilite_bready) begin
            s_axilite_bvalid <= 1'b0;
        end
    end

    // One-cycle write pulse, aligned with the updated register value and bvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr_o <= '0;
        end else begin
            reg_wr_o <= wr_ok ? (NUM_REGS'(1) << wr_idx) : '0;
        end
    end

    // Register storage; read-only slots are never written and stay zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && (wr_idx == IDX_W'(i))) begin
                    regs[i] <= wr_merged;
                end
            end
`ifdef GPGPU_CSR_IRQ_EN
            regs[NUM_REGS-1] <= irq_next;
`endif
        end
    end

    // Read data is captured at the AR handshake, so a same-edge commit is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axilite_rvalid <= 1'b0;
            s_axilite_rdata  <= '0;
            s_axilite_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axilite_rvalid <= 1'b1;
            if (rd_err) begin
                s_axilite_rdata <= '0;
                s_axilite_rresp <= RESP_SLVERR;
            end else if (RO_EFF[rd_idx]) begin
                s_axilite_rdata <= ro_data_i[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];
                s_axilite_rresp <= RESP_OKAY;
            end else begin
                s_axilite_rdata <= regs[rd_idx];
                s_axilite_rresp <= RESP_OKAY;
            end
        end else if (s_axilite_rready) begin
            s_axilite_rvalid <= 1'b0;
        end
    end

    // Flattened view of the RW registers; read-only slots read as zero here.
    always_comb begin
        reg_q_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_EFF[i] ? '0 : regs[i];
        end
    end

endmodule

// File: tb/tb_gpgpu_axil_csr_bank.sv
// tb/tb_gpgpu_axil_csr_bank.sv - directed plus randomized self-checking bench for gpgpu_axil_csr_bank
module tb_gpgpu_axil_csr_bank;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0004;

    typedef logic [NR*DW-1:0] wide_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          awvalid = 1'b0, awready;
    logic [AW-1:0] awaddr = '0;
    logic [2:0]    awprot = 3'b0;
    logic          wvalid = 1'b0, wready;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          bvalid, bready = 1'b0;
    logic [1:0]    bresp;
    logic          arvalid = 1'b0, arready;
    logic [AW-1:0] araddr = '0;
    logic [2:0]    arprot = 3'b0;
    logic          rvalid, rready = 1'b0;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    wide_t         reg_q;
    logic [NR-1:0] reg_wr;
    wide_t         ro_vec = '0;
    logic [DW-1:0] irq_set = '0;
    logic          irq;

    int compared = 0;
    int mismatched = 0;
    logic [DW-1:0] model [NR];

    gpgpu_axil_csr_bank #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axilite_awvalid(awvalid), .s_axilite_awready(awready),
        .s_axilite_awaddr(awaddr), .s_axilite_awprot(awprot),
        .s_axilite_wvalid(wvalid), .s_axilite_wready(wready),
        .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb),
        .s_axilite_bvalid(bvalid), .s_axilite_bready(bready), .s_axilite_bresp(bresp),
        .s_axilite_arvalid(arvalid), .s_axilite_arready(arready),
        .s_axilite_araddr(araddr), .s_axilite_arprot(arprot),
        .s_axilite_rvalid(rvalid), .s_axilite_rready(rready),
        .s_axilite_rdata(rdata), .s_axilite_rresp(rresp),
        .reg_q_o(reg_q), .reg_wr_o(reg_wr), .ro_data_i(ro_vec),
        .irq_set_i(irq_set), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wide_t model_flat();
        wide_t f = '0;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = RO[i] ? '0 : model[i];
        return f;
    endfunction

    // Reference write rule: decode range, RO check, byte merge, W1C on the status register.
    function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                               input logic [3:0] s, output logic [NR-1:0] pulse);
        int idx = int'(a / 4) % NR;
        logic [DW-1:0] m = '0;
        pulse = '0;
        if (a >= AW'(NR*4)) return 2'b10;
        if (RO[idx]) return 2'b10;
        for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
`ifdef GPGPU_CSR_IRQ_EN
        if (idx == NR-1) model[idx] = model[idx] & ~(d & m);
        else model[idx] = (model[idx] & ~m) | (d & m);
`else
        model[idx] = (model[idx] & ~m) | (d & m);
`endif
        pulse = NR'(1) << idx;
        return 2'b00;
    endfunction

    task automatic send_aw(input logic [AW-1:0] a, input int dly);
        int t = 0;
        repeat (dly) @(negedge clk);
        awaddr = a;
        awvalid = 1'b1;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        chk("aw_ready", wide_t'(awready), wide_t'(1));
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [3:0] s, input int dly);
        int t = 0;
        repeat (dly) @(negedge clk);
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        while (!wready && t < 50) begin @(negedge clk); t++; end
        chk("w_ready", wide_t'(wready), wide_t'(1));
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic await_b(output logic [NR-1:0] pulse);
        int t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        pulse = reg_wr;
        chk("b_valid", wide_t'(bvalid), wide_t'(1));
    endtask

    task automatic accept_b();
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input int daw, input int dw);
        logic [1:0] er;
        logic [NR-1:0] ep, p;
        er = model_write(a, d, s, ep);
        fork
            send_aw(a, daw);
            send_w(d, s, dw);
        join
        await_b(p);
        chk("wr_bresp", wide_t'(bresp), wide_t'(er));
        chk("wr_pulse", wide_t'(p), wide_t'(ep));
        chk("wr_regq", reg_q, model_flat());
        accept_b();
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int t = 0;
        int idx = int'(a / 4) % NR;
        logic [DW-1:0] ed;
        logic [1:0] er;
        if (a >= AW'(NR*4)) begin ed = '0; er = 2'b10; end
        else if (RO[idx]) begin ed = ro_vec[idx*DW +: DW]; er = 2'b00; end
        else begin ed = model[idx]; er = 2'b00; end
        araddr = a;
        arvalid = 1'b1;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        chk("rd_rvalid", wide_t'(rvalid), wide_t'(1));
        chk("rd_rdata", wide_t'(rdata), wide_t'(ed));
        chk("rd_rresp", wide_t'(rresp), wide_t'(er));
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_awready"}, wide_t'(awready), wide_t'(1));
        chk({tag, "_wready"},  wide_t'(wready),  wide_t'(1));
        chk({tag, "_arready"}, wide_t'(arready), wide_t'(1));
        chk({tag, "_bvalid"},  wide_t'(bvalid),  wide_t'(0));
        chk({tag, "_bresp"},   wide_t'(bresp),   wide_t'(0));
        chk({tag, "_rvalid"},  wide_t'(rvalid),  wide_t'(0));
        chk({tag, "_rdata"},   wide_t'(rdata),   wide_t'(0));
        chk({tag, "_rresp"},   wide_t'(rresp),   wide_t'(0));
        chk({tag, "_regq"},    reg_q,            wide_t'(0));
        chk({tag, "_regwr"},   wide_t'(reg_wr),  wide_t'(0));
        chk({tag, "_irq"},     wide_t'(irq),     wide_t'(0));
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [NR-1:0] p;
        int op;

        for (int i = 0; i < NR; i++) begin
            model[i] = '0;
            ro_vec[i*DW +: DW] = $urandom;
        end
        ro_vec[2*DW +: DW] = 32'h12345678;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");

        // AW and W in the same cycle: bvalid two cycles later with the pulse.
        awaddr = 32'h4; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_bvalid_c1", wide_t'(bvalid), wide_t'(0));
        @(negedge clk);
        chk("t1_bvalid_c2", wide_t'(bvalid), wide_t'(1));
        chk("t1_bresp", wide_t'(bresp), wide_t'(0));
        chk("t1_reg1", wide_t'(reg_q[1*DW +: DW]), wide_t'(32'hDEADBEEF));
        chk("t1_pulse", wide_t'(reg_wr), wide_t'(16'h0002));
        @(negedge clk);
        chk("t1_pulse_gone", wide_t'(reg_wr), wide_t'(0));
        chk("t1_bvalid_held", wide_t'(bvalid), wide_t'(1));
        accept_b();
        model[1] = 32'hDEADBEEF;
        do_read(32'h4);

        // W three cycles ahead of AW, byte strobe; then B backpressure with a second write queued.
        fork
            send_w(32'h0000AB00, 4'b0010, 0);
            send_aw(32'h4, 3);
        join
        await_b(p);
        model[1] = 32'hDEADABEF;
        chk("t2_reg1", wide_t'(reg_q[1*DW +: DW]), wide_t'(32'hDEADABEF));
        fork
            send_aw(32'h14, 0);
            send_w(32'hCAFEF00D, 4'hF, 0);
        join
        for (int i = 0; i < 5; i++) begin
            chk("t2_bvalid_held", wide_t'(bvalid), wide_t'(1));
            chk("t2_reg5_old", wide_t'(reg_q[5*DW +: DW]), wide_t'(model[5]));
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        model[5] = 32'hCAFEF00D;
        chk("t2_bvalid_cont", wide_t'(bvalid), wide_t'(1));
        chk("t2_pulse5", wide_t'(reg_wr), wide_t'(16'h0020));
        chk("t2_reg5_new", wide_t'(reg_q[5*DW +: DW]), wide_t'(32'hCAFEF00D));
        accept_b();
        chk("t2_bvalid_drop", wide_t'(bvalid), wide_t'(0));

        // Read-only register and decode error.
        do_write(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0);
        do_read(32'h8);
        do_read(32'h40);

        // Same-edge read handshake and commit on reg3.
        do_write(32'hC, 32'h1, 4'hF, 0, 1);
        awaddr = 32'hC; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'hC; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("t4_rvalid", wide_t'(rvalid), wide_t'(1));
        chk("t4_rdata_old", wide_t'(rdata), wide_t'(32'h1));
        chk("t4_bvalid", wide_t'(bvalid), wide_t'(1));
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        model[3] = 32'h2;
        do_read(32'hC);

`ifdef GPGPU_CSR_IRQ_EN
        irq_set = 32'h5;
        @(negedge clk);
        irq_set = '0;
        model[NR-1] = 32'h5;
        chk("irq_high", wide_t'(irq), wide_t'(1));
        do_write(32'h3C, 32'h1, 4'hF, 0, 0);
        chk("irq_still", wide_t'(irq), wide_t'(1));
        do_read(32'h3C);
        awaddr = 32'h3C; awvalid = 1'b1; wdata = 32'h4; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; irq_set = 32'h4;
        @(negedge clk);
        irq_set = '0;
        chk("irq_setwins_b", wide_t'(bvalid), wide_t'(1));
        chk("irq_setwins_q", wide_t'(reg_q[(NR-1)*DW +: DW]), wide_t'(32'h4));
        chk("irq_setwins_o", wide_t'(irq), wide_t'(1));
        accept_b();
        model[NR-1] = 32'h4;
`else
        irq_set = 32'h5;
        @(negedge clk);
        irq_set = '0;
        @(negedge clk);
        chk("irq_disabled", wide_t'(irq), wide_t'(0));
        chk("irq_reg15", wide_t'(reg_q[(NR-1)*DW +: DW]), wide_t'(model[NR-1]));
`endif

        // Randomized writes/reads against the reference model.
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 2);
            a = AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
`ifdef GPGPU_CSR_IRQ_EN
            if (a >= 32'h3C && a < 32'h40) a = a - 32'h4;
`endif
            if (op != 0) do_write(a, $urandom, 4'($urandom_range(0, 15)),
                                  $urandom_range(0, 3), $urandom_range(0, 3));
            else do_read(a);
        end

        // Reset with AW held and W pending discards the transaction.
        awaddr = 32'h0; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1; rst = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(negedge clk);
        chk_reset_state("rst2");
        repeat (3) @(negedge clk);
        chk("rst2_no_b", wide_t'(bvalid), wide_t'(0));
        do_read(32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gpgpu_axil_csr_bank.md
# gpgpu_axil_csr_bank

Parametrised AXI4-Lite slave register bank: the host-facing control/status front end of the GPGPU top, sitting between the SoC AXI-Lite interconnect and the kernel-launch logic. Accepts AW and W independently, commits byte-strobed writes into `NUM_REGS` registers, and returns read data from RW registers or hardware-driven read-only registers. Drives a per-register write pulse, and optionally an interrupt status register.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, AXI-Lite address width
- `DATA_WIDTH`, 32, register/bus width; 32 or 64 only
- `NUM_REGS`, 16, register count; power of two, ≥2
- `RO_MASK`, 0, `NUM_REGS`-bit mask; bit i=1 makes register i read-only (value from `ro_data_i`)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `s_axilite_aw{valid,ready,addr,prot}`  in/out/in/in  1/1/`ADDR_WIDTH`/3  write address; prot ignored
- `s_axilite_w{valid,ready,data,strb}`  in/out/in/in  1/1/`DATA_WIDTH`/`DATA_WIDTH/8`  write data
- `s_axilite_b{valid,ready,resp}`  out/in/out  1/1/2  write response
- `s_axilite_ar{valid,ready,addr,prot}`  in/out/in/in  1/1/`ADDR_WIDTH`/3  read address; prot ignored
- `s_axilite_r{valid,ready,data,resp}`  out/in/out/out  1/1/`DATA_WIDTH`/2  read data
- `reg_q_o`  out  `NUM_REGS*DATA_WIDTH`  flattened RW register contents, reg i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `reg_wr_o`  out  `NUM_REGS`  one-cycle pulse per committed write
- `ro_data_i`  in  `NUM_REGS*DATA_WIDTH`  values for RO registers
- `irq_set_i`  in  `DATA_WIDTH`  interrupt status set bits
- `irq_o`  out  1  interrupt request

## Operation
- Decode: `OFF = log2(DATA_WIDTH/8)`; index = `addr[OFF+log2(NUM_REGS)-1:OFF]`; low `OFF` bits ignored. Address ≥ `NUM_REGS*DATA_WIDTH/8` → decode error.
- Write path: one-entry AW holding buffer and one-entry W holding buffer. `awready = !aw_held`, `wready = !w_held`. Commit when `aw_held && w_held && (!bvalid || bready)`: register updated per `wstrb` byte, `reg_wr_o[idx]` pulses, buffers cleared, bvalid set.
- bresp: `OKAY` (2'b00) on normal write; `SLVERR` (2'b10) on decode error or write to RO register; no register change and no `reg_wr_o` pulse in error cases.
- Read path: `arready = !rvalid`. On AR handshake, rdata/rresp registered: RW reg → stored value; RO reg → `ro_data_i` slice sampled at handshake; decode error → rdata 0, `SLVERR`. Held stable until `rready`.
- RO registers: `reg_q_o` slice is 0.
- Same-cycle read handshake and write commit to same register: read returns pre-write value.
- `rst`: all registers 0, buffers emptied, pending transactions discarded (no B/R issued).

## Timing
- Reset values: `awready`/`wready`/`arready` 1 (cycle after reset deasserts), `bvalid` 0, `bresp` 0, `rvalid` 0, `rdata` 0, `rresp` 0, `reg_q_o` 0, `reg_wr_o` 0, `irq_o` 0.
- Write: AW+W handshake in cycle 0 → commit edge ending cycle 1 → `bvalid`, new `reg_q_o`, `reg_wr_o` pulse all visible cycle 2. AW and W may arrive any cycles apart and in either order; latency counts from the later one.
- B backpressure: while `bvalid && !bready`, both buffers may fill but no commit occurs; commit in the cycle `bready` is seen, `bvalid` stays high continuously for the next response.
- Read: AR in cycle 0 → `rvalid` cycle 1; next AR accepted the cycle after `rvalid && rready`.

## Configuration
- `GPGPU_CSR_IRQ_EN` defined: register `NUM_REGS-1` is interrupt status. Each cycle bits of `irq_set_i` are OR-set; host write clears bits where data=1 (W1C, strobe-qualified). Set wins over clear on the same bit in the same cycle. `irq_o = |status`, so high the cycle after the set pulse. That register is forced RW regardless of `RO_MASK`.
- Undefined: register `NUM_REGS-1` is ordinary per `RO_MASK`, `irq_set_i` ignored, `irq_o` tied 0.

## Test plan
- Reset, then write 0xDEADBEEF strb 4'hF to 0x04 with AW/W same cycle → bvalid cycle 2, bresp 0, `reg_q_o` reg1 = 0xDEADBEEF, `reg_wr_o`=0x0002 for one cycle; read 0x04 → rdata 0xDEADBEEF, rresp 0.
- W three cycles before AW, strb 4'b0010 data 0x0000AB00 onto reg1 → reg1 = 0xDEADABEF; bready low 5 cycles → bvalid held, second write commits only after first B accepted.
- `RO_MASK`=0x4, `ro_data_i` reg2 = 0x12345678: write 0x08 → SLVERR, no pulse; read 0x08 → 0x12345678 OKAY; read 0x40 (NUM_REGS=16) → rdata 0, SLVERR.
- Same-cycle read handshake and commit on reg3 (old 0x1, new 0x2) → read returns 0x1, next read 0x2.
- `GPGPU_CSR_IRQ_EN`: pulse `irq_set_i`=0x5 → irq_o high next cycle; write 0x1 to reg15 → status 0x4, irq_o stays 1; write 0x4 with simultaneous set 0x4 → status 0x4 stays.
- Assert `rst` with AW held and W pending → no bvalid, all outputs at reset values, registers 0.
